// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Shared types and constants for the MIPS memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/ram_async_rd.sv
`default_nettype none
// ============================================================================
//  Module      : ram_async_rd
//  Description : Word RAM with synchronous write and asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_async_rd #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    // Contents are deliberately not reset so a program survives a core reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mips_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_responder
//  Description : Harvard IMEM/DMEM responder with byte-serial program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int IMEM_AW = 6,
    parameter int DMEM_AW = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    input  logic        mem_write,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        core_rst_n,
    output logic        misalign
);

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_byte_idx;
    logic [IMEM_AW-1:0]   r_word_ptr;
    logic [31:0]          r_shift;
    logic                 r_core_rst_n;
    logic                 r_misalign;

    logic                 w_run;
    logic                 w_accept;
    logic                 w_imem_we;
    logic [31:0]          w_asm_word;
    logic                 w_dmem_we;
    logic [31:0]          w_imem_rdata;
    logic [31:0]          w_dmem_rdata;
    logic                 w_unused;

    assign w_run     = (r_state == ST_RUN);
    assign ld_ready  = (r_state == ST_LOAD);
    assign w_accept  = ld_ready && ld_valid;
    assign w_imem_we = w_accept && ((r_byte_idx == 2'd3) || ld_last);
    assign w_dmem_we = w_run && mem_write;

    // Left-justify the bytes collected so far; unfilled low bytes become zero.
    assign w_asm_word = {r_shift[23:0], ld_data} << {(2'd3 - r_byte_idx), 3'b000};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (ld_start) w_next_state = ST_LOAD;
            ST_LOAD: if (w_accept && ld_last) w_next_state = ST_RUN;
            ST_RUN:  w_next_state = ST_RUN;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_byte_idx   <= 2'd0;
            r_word_ptr   <= '0;
            r_shift      <= 32'h0;
            r_core_rst_n <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_core_rst_n <= (w_next_state == ST_RUN);
            if (w_accept) begin
                r_shift    <= w_imem_we ? 32'h0 : {r_shift[23:0], ld_data};
                r_byte_idx <= ld_last ? 2'd0 : r_byte_idx + 2'd1;
            end
            if (w_imem_we) begin
                r_word_ptr <= r_word_ptr + 1'b1;
            end
            if (w_dmem_we && (alu_out[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end
        end
    end

    ram_async_rd #(
        .AW (IMEM_AW),
        .DW (32)
    ) u_imem (
        .clk     (clk),
        .i_we    (w_imem_we),
        .i_waddr (r_word_ptr),
        .i_wdata (w_asm_word),
        .i_raddr (pc[IMEM_AW+1:2]),
        .o_rdata (w_imem_rdata)
    );

    ram_async_rd #(
        .AW (DMEM_AW),
        .DW (32)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_dmem_we),
        .i_waddr (alu_out[DMEM_AW+1:2]),
        .i_wdata (write_data),
        .i_raddr (alu_out[DMEM_AW+1:2]),
        .o_rdata (w_dmem_rdata)
    );

    assign instr      = w_run ? w_imem_rdata : MIPS_NOP;
    assign read_data  = w_run ? w_dmem_rdata : 32'h0;
    assign core_rst_n = r_core_rst_n;
    assign misalign   = r_misalign;

    assign w_unused = &{1'b0, pc[31:IMEM_AW+2], pc[1:0], alu_out[31:DMEM_AW+2]};

endmodule
`default_nettype wire
